i2c_bus_monitor: RTL and testbench
==================================

// Module: i2c_bus_monitor
// PURPOSE
//  Passive consumer of the sampled I2C bus lines (scl_i/sda_i) of the I2C interface.
//  Synchronises and de-glitches both lines, detects START/repeated-START/STOP, and
//  deserialises 8 data bits + ACK per byte. Emits one event per bus condition or byte
//  into a small FWFT event FIFO read via valid/ready. Never drives the bus.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop stages per line in the input synchroniser (>=2)
//  GLITCH_FILT  3  consecutive stable pclk samples required before a filtered line changes (>=1)
//  FIFO_DEPTH   4  event FIFO entries (power of 2, >=2)
// PORTS
//  pclk       in   1  system clock; all logic on rising edge
//  areset     in   1  reset, synchronous, active-high
//  scl_i      in   1  sampled I2C clock line (asynchronous to pclk)
//  sda_i      in   1  sampled I2C data line (asynchronous to pclk)
//  evt_valid  out  1  FIFO head holds an event
//  evt_ready  in   1  consumer accepts head this cycle when evt_valid=1
//  evt_type   out  2  0=START 1=RSTART 2=STOP 3=BYTE
//  evt_data   out  8  received byte, MSB first on wire (0 for non-BYTE events)
//  evt_ack    out  1  sda sampled in 9th bit (0=ACK, 1=NACK); 0 for non-BYTE
//  evt_err    out  1  START/RSTART/STOP arrived with bit count !=0 (partial byte dropped)
//  bus_busy   out  1  1 between START and STOP
//  overflow   out  1  sticky: an event was dropped because FIFO was full
// BEHAVIOUR
//  Reset (areset=1 at pclk edge): sync/filter regs=1 (idle high), state=IDLE, bit_cnt=0,
//   FIFO empty; evt_valid=0, evt_type/data/ack/err=0, bus_busy=0, overflow=0. Reset mid-byte
//   abandons the byte silently; no event.
//  Filter: filtered line takes new value after raw synchronised value differs from it for
//   GLITCH_FILT consecutive cycles; shorter pulses ignored. Edges = filtered vs previous.
//  Conditions (evaluated per cycle on filtered lines):
//   START: sda fall while scl high both cycles; STATE IDLE->ACTIVE, type START, bus_busy=1.
//   RSTART: same condition in ACTIVE; type RSTART, stays ACTIVE.
//   STOP: sda rise while scl high both cycles; ACTIVE->IDLE, type STOP, bus_busy=0.
//   scl and sda changing in same filtered cycle: no START/STOP; only scl edge processed.
//  Data (ACTIVE only): on scl rise, bit_cnt 0..7 shift sda into byte MSB first; bit_cnt 8
//   captures ack, pushes BYTE event, bit_cnt->0. scl edges in IDLE ignored.
//  Any START/RSTART/STOP clears bit_cnt; evt_err=1 on that event iff bit_cnt was !=0.
//  Latency: raw pin change -> evt_valid = SYNC_STAGES+GLITCH_FILT+2 pclk with FIFO empty.
//  FIFO: FWFT; pop when evt_valid&&evt_ready. Push when full: event dropped, overflow<=1
//   (cleared only by reset), unless a pop occurs same cycle -> push accepted. Outputs hold
//   stable while evt_valid&&!evt_ready. At most one push per cycle by construction.
// STRUCTURE
//  Package i2c_mon_pkg: typedef enum logic[1:0] i2c_evt_e {EVT_START,EVT_RSTART,EVT_STOP,
//   EVT_BYTE}; typedef struct packed i2c_evt_s {type,data[7:0],ack,err}; state enum
//   {MON_IDLE,MON_ACTIVE}.
//  Sub-module i2c_glitch_filter (SYNC_STAGES, GLITCH_FILT; pclk, areset, din, dout),
//   instantiated once per line, reset output 1. FIFO kept inline.
// TESTING
//  1 START, addr 0xA4 + ACK, data 0x3C + NACK, STOP, ready=1 -> events START, BYTE(A4,ack0),
//    BYTE(3C,ack1), STOP, err=0; bus_busy 1 then 0.
//  2 START, 0x50+ACK, RSTART, 0x51+ACK, STOP -> START,BYTE,RSTART,BYTE,STOP; bus_busy stays 1
//    across RSTART.
//  3 START, 3 bits, STOP -> START, STOP with err=1; no BYTE; next transaction decodes cleanly.
//  4 sda pulses of GLITCH_FILT-1 cycles while scl high in IDLE -> no events; pulse of
//    GLITCH_FILT cycles -> START.
//  5 evt_ready=0, 6 events -> first 4 held stable, last 2 dropped, overflow=1; drain keeps
//    overflow=1; full+pop+push same cycle -> no drop.
//  6 areset mid-byte (bit 5) -> all outputs reset values next cycle, FIFO empty, no event.

Source files
------------

// File: rtl/i2c_mon_pkg.sv
// Shared types for the I2C bus monitor.
//   i2c_evt_e : event kind reported through the event FIFO
//   i2c_evt_s : one FIFO entry (kind, byte, ack bit, partial-byte error)
//   mon_state_e : monitor bus state
package i2c_mon_pkg;

  typedef enum logic [1:0] {
    EVT_START  = 2'd0,
    EVT_RSTART = 2'd1,
    EVT_STOP   = 2'd2,
    EVT_BYTE   = 2'd3
  } i2c_evt_e;

  typedef struct packed {
    i2c_evt_e   typ;
    logic [7:0] data;
    logic       ack;
    logic       err;
  } i2c_evt_s;

  typedef enum logic {
    MON_IDLE   = 1'b0,
    MON_ACTIVE = 1'b1
  } mon_state_e;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchroniser plus de-glitch filter for one I2C line.
//   pclk   : system clock
//   areset : synchronous active-high reset (output returns to idle-high)
//   din    : raw line, asynchronous to pclk
//   dout   : filtered line; follows din only after GLITCH_FILT stable samples
module i2c_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_FILT = 3
) (
  input  logic pclk,
  input  logic areset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(GLITCH_FILT + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_out;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign dout   = r_out;

  always_ff @(posedge pclk) begin
    if (areset) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_out  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      if (w_sync != r_out) begin
        if (r_cnt == CW'(GLITCH_FILT - 1)) begin
          r_out <= w_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor. Filters SCL/SDA, detects START/RSTART/STOP,
// deserialises bytes + ACK and queues one event per condition/byte in a
// first-word-fall-through FIFO.
//   pclk, areset           : clock, synchronous active-high reset
//   scl_i, sda_i           : raw bus lines (never driven)
//   evt_valid / evt_ready  : FIFO head handshake
//   evt_type/data/ack/err  : head event fields (zero while FIFO empty)
//   bus_busy               : high between START and STOP
//   overflow               : sticky, an event was dropped on a full FIFO
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_FILT = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       pclk,
  input  logic       areset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_type,
  output logic [7:0] evt_data,
  output logic       evt_ack,
  output logic       evt_err,
  output logic       bus_busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic w_scl, w_sda;

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_FILT(GLITCH_FILT)) u_scl_filt (
    .pclk(pclk), .areset(areset), .din(scl_i), .dout(w_scl)
  );

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_FILT(GLITCH_FILT)) u_sda_filt (
    .pclk(pclk), .areset(areset), .din(sda_i), .dout(w_sda)
  );

  mon_state_e r_state;
  logic       r_scl_q, r_sda_q;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_cnt_lo;
  logic [7:0] r_shift;
  logic       r_busy;
  logic       r_push;
  i2c_evt_s   r_evt;

  logic w_start, w_stop, w_scl_rise, w_scl_fall;

  // Conditions need SCL high in both cycles, so a simultaneous SCL change
  // never produces START/STOP and only the SCL edge is processed.
  assign w_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign w_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;
  assign w_scl_rise = ~r_scl_q & w_scl;
  assign w_scl_fall = r_scl_q & ~w_scl;

  // The SCL pulse that frames a STOP/RSTART is counted as a bit on its rising
  // edge. Partial-byte errors therefore use r_cnt_lo, the bit count captured
  // at the last SCL fall, so a clean byte followed by STOP/RSTART is err=0.
  always_ff @(posedge pclk) begin
    if (areset) begin
      r_state   <= MON_IDLE;
      r_scl_q   <= 1'b1;
      r_sda_q   <= 1'b1;
      r_bit_cnt <= '0;
      r_cnt_lo  <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_push    <= 1'b0;
      r_evt     <= '0;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
      r_push  <= 1'b0;
      if (w_start) begin
        r_push     <= 1'b1;
        r_evt.typ  <= (r_state == MON_ACTIVE) ? EVT_RSTART : EVT_START;
        r_evt.data <= '0;
        r_evt.ack  <= 1'b0;
        r_evt.err  <= (r_cnt_lo != '0);
        r_state    <= MON_ACTIVE;
        r_busy     <= 1'b1;
        r_bit_cnt  <= '0;
        r_cnt_lo   <= '0;
      end else if (w_stop && r_state == MON_ACTIVE) begin
        r_push     <= 1'b1;
        r_evt.typ  <= EVT_STOP;
        r_evt.data <= '0;
        r_evt.ack  <= 1'b0;
        r_evt.err  <= (r_cnt_lo != '0);
        r_state    <= MON_IDLE;
        r_busy     <= 1'b0;
        r_bit_cnt  <= '0;
        r_cnt_lo   <= '0;
      end else if (r_state == MON_ACTIVE) begin
        if (w_scl_rise) begin
          if (r_bit_cnt == 4'd8) begin
            r_push     <= 1'b1;
            r_evt.typ  <= EVT_BYTE;
            r_evt.data <= r_shift;
            r_evt.ack  <= w_sda;
            r_evt.err  <= 1'b0;
            r_bit_cnt  <= '0;
          end else begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end else if (w_scl_fall) begin
          r_cnt_lo <= r_bit_cnt;
        end
      end
    end
  end

  // Event FIFO
  i2c_evt_s        r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic            w_full, w_pop, w_wr;
  i2c_evt_s        w_head;

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid & evt_ready;
  assign w_wr      = r_push & (~w_full | w_pop);
  assign w_head    = r_mem[r_rd];

  always_ff @(posedge pclk) begin
    if (areset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!areset && w_wr) r_mem[r_wr] <= r_evt;
  end

  assign evt_type = evt_valid ? w_head.typ  : 2'd0;
  assign evt_data = evt_valid ? w_head.data : 8'd0;
  assign evt_ack  = evt_valid ? w_head.ack  : 1'b0;
  assign evt_err  = evt_valid ? w_head.err  : 1'b0;
  assign bus_busy = r_busy;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: drives I2C waveforms on scl_i/sda_i,
// collects popped events and checks them against hand-computed values.
module tb_i2c_bus_monitor;

  localparam int H = 10;

  logic       pclk = 1'b0;
  logic       areset, scl_i, sda_i, evt_ready;
  logic       evt_valid, evt_ack, evt_err, bus_busy, overflow;
  logic [1:0] evt_type;
  logic [7:0] evt_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] q [$];

  i2c_bus_monitor #(.SYNC_STAGES(2), .GLITCH_FILT(3), .FIFO_DEPTH(4)) dut (
    .pclk(pclk), .areset(areset), .scl_i(scl_i), .sda_i(sda_i),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_data(evt_data), .evt_ack(evt_ack), .evt_err(evt_err),
    .bus_busy(bus_busy), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk)
    if (evt_valid && evt_ready) q.push_back({evt_type, evt_data, evt_ack, evt_err});

  function automatic logic [11:0] ev(input logic [1:0] t, input logic [7:0] d,
                                     input logic a, input logic e);
    return {t, d, a, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = 12'hFFF;
    if (q.size() != 0) got = q.pop_front();
    chk(tag, {20'd0, got}, {20'd0, exp});
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic i2c_start();
    sda_i = 1'b0; wt(H); scl_i = 1'b0; wt(H);
  endtask

  task automatic i2c_bit(input logic b);
    sda_i = b; wt(H); scl_i = 1'b1; wt(H); scl_i = 1'b0; wt(H);
  endtask

  task automatic i2c_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
    i2c_bit(a);
  endtask

  task automatic i2c_stop();
    sda_i = 1'b0; wt(H); scl_i = 1'b1; wt(H); sda_i = 1'b1; wt(2 * H);
  endtask

  task automatic i2c_rstart();
    sda_i = 1'b1; wt(H); scl_i = 1'b1; wt(H); sda_i = 1'b0; wt(H); scl_i = 1'b0; wt(H);
  endtask

  initial begin
    areset = 1'b1; scl_i = 1'b1; sda_i = 1'b1; evt_ready = 1'b1;
    wt(3);
    chk("reset_outputs",
        {18'd0, evt_valid, bus_busy, overflow, evt_type, evt_data, evt_ack, evt_err}, 32'd0);
    areset = 1'b0;
    wt(5);

    // 1: START, A4+ACK, 3C+NACK, STOP; START latency is 7 cycles
    sda_i = 1'b0;
    wt(6);
    chk("t1_latency_before", {31'd0, evt_valid}, 32'd0);
    wt(1);
    chk("t1_latency_at", {31'd0, evt_valid}, 32'd1);
    wt(H - 7); scl_i = 1'b0; wt(H);
    chk("t1_busy_after_start", {31'd0, bus_busy}, 32'd1);
    i2c_byte(8'hA4, 1'b0);
    i2c_byte(8'h3C, 1'b1);
    i2c_stop();
    chk("t1_busy_after_stop", {31'd0, bus_busy}, 32'd0);
    chk_ev("t1_ev0_start", ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t1_ev1_byte",  ev(2'd3, 8'hA4, 1'b0, 1'b0));
    chk_ev("t1_ev2_byte",  ev(2'd3, 8'h3C, 1'b1, 1'b0));
    chk_ev("t1_ev3_stop",  ev(2'd2, 8'h00, 1'b0, 1'b0));
    chk("t1_empty", q.size(), 32'd0);

    // 2: repeated START keeps bus busy
    i2c_start();
    i2c_byte(8'h50, 1'b0);
    i2c_rstart();
    chk("t2_busy_after_rstart", {31'd0, bus_busy}, 32'd1);
    i2c_byte(8'h51, 1'b0);
    i2c_stop();
    chk_ev("t2_ev0_start",  ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t2_ev1_byte",   ev(2'd3, 8'h50, 1'b0, 1'b0));
    chk_ev("t2_ev2_rstart", ev(2'd1, 8'h00, 1'b0, 1'b0));
    chk_ev("t2_ev3_byte",   ev(2'd3, 8'h51, 1'b0, 1'b0));
    chk_ev("t2_ev4_stop",   ev(2'd2, 8'h00, 1'b0, 1'b0));
    chk("t2_empty", q.size(), 32'd0);

    // 3: partial byte then STOP flags err; next transfer clean
    i2c_start();
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
    i2c_stop();
    chk_ev("t3_ev0_start",    ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t3_ev1_stop_err", ev(2'd2, 8'h00, 1'b0, 1'b1));
    chk("t3_no_byte", q.size(), 32'd0);
    i2c_start();
    i2c_byte(8'hC3, 1'b0);
    i2c_stop();
    chk_ev("t3_ev2_start", ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t3_ev3_byte",  ev(2'd3, 8'hC3, 1'b0, 1'b0));
    chk_ev("t3_ev4_stop",  ev(2'd2, 8'h00, 1'b0, 1'b0));

    // 4: short SDA pulses ignored; 3-cycle pulse seen as START then STOP
    sda_i = 1'b0; wt(2); sda_i = 1'b1; wt(H);
    sda_i = 1'b0; wt(2); sda_i = 1'b1; wt(H);
    chk("t4_glitch_no_event", q.size(), 32'd0);
    chk("t4_glitch_idle", {31'd0, bus_busy}, 32'd0);
    sda_i = 1'b0; wt(3); sda_i = 1'b1; wt(2 * H);
    chk_ev("t4_pulse_start", ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t4_pulse_stop",  ev(2'd2, 8'h00, 1'b0, 1'b0));

    // 5: overflow with consumer stalled
    evt_ready = 1'b0;
    i2c_start();
    i2c_byte(8'h11, 1'b0); i2c_byte(8'h22, 1'b0);
    i2c_byte(8'h33, 1'b0); i2c_byte(8'h44, 1'b0);
    i2c_stop();
    chk("t5_head_held", {18'd0, evt_valid, overflow, evt_type, evt_data, evt_ack, evt_err},
        {18'd0, 1'b1, 1'b1, 12'h000});
    wt(H);
    chk("t5_head_stable", {20'd0, evt_type, evt_data, evt_ack, evt_err}, 32'd0);
    evt_ready = 1'b1; wt(6); evt_ready = 1'b0; wt(2);
    chk_ev("t5_d0", ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t5_d1", ev(2'd3, 8'h11, 1'b0, 1'b0));
    chk_ev("t5_d2", ev(2'd3, 8'h22, 1'b0, 1'b0));
    chk_ev("t5_d3", ev(2'd3, 8'h33, 1'b0, 1'b0));
    chk("t5_drained", {30'd0, evt_valid, overflow}, 32'd1);
    // fill to full, then pop in exactly the STOP push cycle
    i2c_start();
    i2c_byte(8'h55, 1'b0); i2c_byte(8'h66, 1'b0); i2c_byte(8'h77, 1'b0);
    sda_i = 1'b0; wt(H); scl_i = 1'b1; wt(H);
    sda_i = 1'b1; wt(6);
    evt_ready = 1'b1; wt(1); evt_ready = 1'b0; wt(H);
    evt_ready = 1'b1; wt(H);
    chk_ev("t5_f0", ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t5_f1", ev(2'd3, 8'h55, 1'b0, 1'b0));
    chk_ev("t5_f2", ev(2'd3, 8'h66, 1'b0, 1'b0));
    chk_ev("t5_f3", ev(2'd3, 8'h77, 1'b0, 1'b0));
    chk_ev("t5_f4_stop_kept", ev(2'd2, 8'h00, 1'b0, 1'b0));
    chk("t5_empty", q.size(), 32'd0);

    // 6: reset in the middle of a byte
    evt_ready = 1'b0;
    i2c_start();
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b1); i2c_bit(1'b0);
    chk("t6_pre_reset", {29'd0, evt_valid, bus_busy, overflow}, 32'd7);
    areset = 1'b1; wt(1);
    chk("t6_reset_outputs",
        {18'd0, evt_valid, bus_busy, overflow, evt_type, evt_data, evt_ack, evt_err}, 32'd0);
    areset = 1'b0; evt_ready = 1'b1;
    sda_i = 1'b1; wt(H); scl_i = 1'b1; wt(3 * H);
    chk("t6_no_event", {31'd0, evt_valid}, 32'd0);
    chk("t6_queue_empty", q.size(), 32'd0);
    i2c_start();
    i2c_byte(8'h5A, 1'b0);
    i2c_stop();
    chk_ev("t6_ev0_start", ev(2'd0, 8'h00, 1'b0, 1'b0));
    chk_ev("t6_ev1_byte",  ev(2'd3, 8'h5A, 1'b0, 1'b0));
    chk_ev("t6_ev2_stop",  ev(2'd2, 8'h00, 1'b0, 1'b0));
    chk("t6_overflow_clear", {31'd0, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
